// File: rtl/tiny16_pkg.sv
// Shared constants and bus types for the tiny16 system.
package tiny16_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned IO_W     = 8;
    localparam int unsigned ST_AVAIL = 15;
    localparam int unsigned ST_OVF   = 14;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [IO_W-1:0]   io_t;

endpackage : tiny16_pkg

// File: rtl/input_port_if.sv
// Controller-side bus view of the input port: read strobe, read word, data-available flag.
interface input_port_if;
    import tiny16_pkg::*;

    logic  out_en;
    word_t out;
    logic  avail;

    modport master (output out_en, input out, input avail);
    modport slave  (input out_en, output out, output avail);

endinterface : input_port_if

// File: rtl/input_fifo.sv
// Small event FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module input_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          wr_en;
    logic          rd_en;

    // Status and pointer advance; a push into a full FIFO only lands when the head leaves this cycle.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left unreset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule : input_fifo

// File: rtl/input_port.sv
// Debounced 8-bit input port: synchronises pins, queues each accepted change, serves it on the bus.
module input_port
    import tiny16_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DEBOUNCE = 16000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IO_W-1:0] pins,
    input_port_if.slave     bus
);

    localparam int unsigned   CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    io_t              sync1_q, sync1_d;
    io_t              sync2_q, sync2_d;
    io_t              cand_q, cand_d;
    io_t              stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             fifo_empty;
    logic             fifo_full;
    io_t              fifo_dout;
    io_t              head;
    word_t            word;

    // Synchronise, track the candidate level, and accept it once it has been steady long enough.
    always_comb begin
        sync1_d  = pins;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        push     = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // stable catching up to the candidate is what makes this a one-shot per level.
        if ((cnt_q == CNT_MAX) && (cand_q != stable_q)) begin
            push     = 1'b1;
            stable_d = cand_q;
        end
    end

    // Bus read, pop and sticky overflow; a fresh overflow outranks the clear-on-read.
    always_comb begin
        pop     = bus.out_en && !fifo_empty;
        ovf_set = push && fifo_full && !pop;
        ovf_d   = ovf_q;
        if (bus.out_en && ovf_q) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        head             = fifo_empty ? '0 : fifo_dout;
        word             = '0;
        word[ST_AVAIL]   = !fifo_empty;
        word[ST_OVF]     = ovf_q;
        word[IO_W-1:0]   = head;
        bus.avail        = !fifo_empty;
        bus.out          = bus.out_en ? word : '0;
    end

    // Port state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    input_fifo #(
        .W     (IO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (cand_q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule : input_port

// File: tb/tb_input_port.sv
// Self-checking bench for input_port: directed scenarios plus random pin/read traffic against a queue model.
module tb_input_port;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DEB   = 4;

    logic       clk;
    logic       rst;
    logic [7:0] pins;

    input_port_if bus_if ();

    input_port #(
        .DEPTH    (DEPTH),
        .DEBOUNCE (DEB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pins (pins),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pin history (newest first), accepted level, event queue and sticky overflow.
    logic [7:0] hist[$];
    logic [7:0] mq[$];
    logic [7:0] m_stable;
    logic       m_ovf;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < int'(DEB) + 3; i++) hist.push_back(8'h00);
        mq       = {};
        m_stable = 8'h00;
        m_ovf    = 1'b0;
    endtask

    // One clock: drive, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic [7:0] p, input logic en, output logic [15:0] seen);
        logic [15:0] exp_out;
        logic        exp_av;
        logic [7:0]  v;
        logic        accept;
        logic        popped;
        logic        ovf_read;
        pins          = p;
        bus_if.out_en = en;
        #1;
        exp_av  = (mq.size() != 0);
        exp_out = 16'h0000;
        if (en) exp_out = {exp_av, m_ovf, 6'b0, (mq.size() != 0) ? mq[0] : 8'h00};
        check("avail", 16'(bus_if.avail), 16'(exp_av));
        check("out", bus_if.out, exp_out);
        seen = bus_if.out;
        @(posedge clk);
        // A level is accepted once the synchronised value has held DEB cycles; sync adds 3 cycles of delay.
        hist.push_front(p);
        void'(hist.pop_back());
        v      = hist[3];
        accept = (v != m_stable);
        for (int i = 3; i < int'(DEB) + 3; i++) if (hist[i] != v) accept = 1'b0;
        ovf_read = en && m_ovf;
        popped   = en && (mq.size() != 0);
        if (popped) void'(mq.pop_front());
        if (ovf_read) m_ovf = 1'b0;
        if (accept) begin
            m_stable = v;
            if (mq.size() < int'(DEPTH)) mq.push_back(v);
            else m_ovf = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic hold(input logic [7:0] p, input logic en, input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i++) step(p, en, w);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset(input logic [7:0] p);
        rst           = 1'b0;
        pins          = p;
        bus_if.out_en = 1'b1;
        #1;
        check("rst_out", bus_if.out, 16'h0000);
        check("rst_avail", 16'(bus_if.avail), 16'h0000);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] w;
        logic [7:0]  cur;
        int          cnt7e;
        rst           = 1'b1;
        pins          = 8'h00;
        bus_if.out_en = 1'b0;
        @(negedge clk);
        do_reset(8'h00);

        // Short glitch must not be accepted.
        hold(8'hFF, 1'b0, 3);
        hold(8'h00, 1'b0, 12);
        check("glitch_avail", 16'(bus_if.avail), 16'h0000);

        // Single step: avail appears after 2 + DEB + 1 edges.
        hold(8'h5A, 1'b0, 7);
        step(8'h5A, 1'b1, w);
        check("step_read", w, 16'h805A);
        hold(8'h5A, 1'b0, 2);

        // Overflow: five changes, four slots.
        do_reset(8'h00);
        hold(8'h11, 1'b0, 9);
        hold(8'h22, 1'b0, 9);
        hold(8'h33, 1'b0, 9);
        hold(8'h44, 1'b0, 9);
        hold(8'h55, 1'b0, 9);
        step(8'h55, 1'b1, w); check("ovf_rd0", w, 16'hC011);
        step(8'h55, 1'b1, w); check("ovf_rd1", w, 16'h8022);
        step(8'h55, 1'b1, w); check("ovf_rd2", w, 16'h8033);
        step(8'h55, 1'b1, w); check("ovf_rd3", w, 16'h8044);
        step(8'h55, 1'b1, w); check("ovf_rd4", w, 16'h0000);

        // Full FIFO with pop on the exact push cycle: no overflow.
        do_reset(8'h00);
        hold(8'h11, 1'b0, 9);
        hold(8'h22, 1'b0, 9);
        hold(8'h33, 1'b0, 9);
        hold(8'h44, 1'b0, 9);
        hold(8'h55, 1'b0, 6);
        step(8'h55, 1'b1, w); check("pp_rd0", w, 16'h8011);
        step(8'h55, 1'b1, w); check("pp_rd1", w, 16'h8022);
        step(8'h55, 1'b1, w); check("pp_rd2", w, 16'h8033);
        step(8'h55, 1'b1, w); check("pp_rd3", w, 16'h8044);
        step(8'h55, 1'b1, w); check("pp_rd4", w, 16'h8055);
        step(8'h55, 1'b1, w); check("pp_rd5", w, 16'h0000);

        // Reset mid-debounce with entries queued; pins held non-zero through release.
        do_reset(8'h00);
        hold(8'h11, 1'b0, 9);
        hold(8'h22, 1'b0, 9);
        hold(8'h3C, 1'b0, 3);
        do_reset(8'h3C);
        hold(8'h3C, 1'b0, 12);
        step(8'h3C, 1'b1, w); check("rst_rd0", w, 16'h803C);
        step(8'h3C, 1'b1, w); check("rst_rd1", w, 16'h0000);

        // Continuous reads while empty, then one change.
        do_reset(8'h00);
        cnt7e = 0;
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b1, w);
            if (w == 16'h807E) cnt7e++;
        end
        for (int i = 0; i < 14; i++) begin
            step(8'h7E, 1'b1, w);
            if (w == 16'h807E) cnt7e++;
        end
        check("cont_count", 16'(cnt7e), 16'd1);

        // Random traffic: mixed glitches, steady levels, sparse reads.
        do_reset(8'h00);
        cur = 8'h00;
        for (int n = 0; n < 60; n++) begin
            int len;
            case ($urandom_range(0, 3))
                0:       cur = 8'($urandom_range(0, 255));
                1:       cur = 8'($urandom_range(0, 3));
                2:       cur = cur ^ 8'h01;
                default: cur = cur;
            endcase
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) step(cur, ($urandom_range(0, 3) == 0), w);
        end
        hold(cur, 1'b1, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_input_port

// File: doc/input_port.md
INPUT_PORT -- requirements
Module: input_port

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the event FIFO depth (power of two, at least 2).
REQ-002 SHALL have parameter DEBOUNCE, default 16000, meaning the number of cycles the input must be stable before it is accepted (1 ms at 16 MHz; at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port pins, input, 8 bits: raw, asynchronous external input (the top-level IN pins).
REQ-006 SHALL have port out_en, input, 1 bit: the controller's bus-read strobe; each high cycle is one read.
REQ-007 SHALL have port out, output, 16 bits: the bus word.
REQ-008 SHALL have port avail, output, 1 bit: high while the FIFO is non-empty; the controller uses it as a poll or wait condition.

Function
REQ-009 SHALL pass pins through a 2-flop synchronizer (sync1, sync2) before any use.
REQ-010 SHALL keep candidate (8 bits) and a debounce counter.
- When sync2 differs from candidate: candidate gets sync2 and the counter clears to 0.
- Otherwise the counter increments, saturating at DEBOUNCE-1.
REQ-011 SHALL update stable to candidate and push candidate into the FIFO on the single cycle where all hold: counter equals DEBOUNCE-1, candidate differs from stable, and no push has yet occurred for that stable period.
REQ-012 SHALL give latency from a pin change to avail rising of 2 (synchronizer) + DEBOUNCE + 1 cycles, provided the FIFO was empty.
REQ-013 SHALL NOT push anything for a glitch shorter than DEBOUNCE cycles.
REQ-014 SHALL drive out = {avail, ovf, 6'b0, head} when out_en is high, and 16'h0000 otherwise.
- head is the FIFO head entry, or 8'h00 when the FIFO is empty.
- out is combinational from the registered state and out_en.
REQ-015 SHALL treat out_en high with the FIFO non-empty as a pop: the read pointer advances at the end of that cycle.
REQ-016 SHALL treat out_en high with the FIFO empty as a read of 16'h0000 (ovf bit excepted) with no pointer change.
REQ-017 SHALL, on a push while full and not popping: drop the new value, keep the FIFO contents, and set sticky flag ovf; stable still updates.
REQ-018 SHALL, on push and pop in the same cycle: perform both, leave the count unchanged, and accept the push even when full (no ovf).
REQ-019 SHALL clear ovf on the cycle after any out_en read that returned ovf=1; a simultaneous overflow event re-sets ovf (set wins).
REQ-020 SHALL use read and write pointers of log2(DEPTH)+1 bits, wrapping naturally.
- Empty: pointers are equal.
- Full: low bits are equal and MSBs differ.
REQ-021 SHALL assert avail as a register-derived output, valid the cycle after the push edge.

Reset
REQ-022 SHALL, while rst=0, asynchronously clear sync1, sync2, candidate, stable, the counter, both pointers and ovf to 0; out SHALL then be 16'h0000 and avail 0.
REQ-023 SHALL abandon any in-progress debounce and discard all FIFO contents when reset is asserted mid-operation.
REQ-024 SHALL treat stable=8'h00 after reset as the baseline, so pins held at a non-zero value through reset produce one push after release.
REQ-025 SHALL NOT require FIFO storage to be reset; stale entries are never observable because the pointers are equal.

Structure
REQ-026 SHALL take these constants from shared package tiny16_pkg: WORD_W=16, IO_W=8, and status bit positions ST_AVAIL=15 and ST_OVF=14.
REQ-027 SHALL implement the FIFO as sub-module input_fifo (parameters W=8 and DEPTH; ports push, pop, din, dout, empty, full), with debounce and bus logic in input_port.
REQ-028 SHALL be instantiated in the top level with out feeding the bus arbitration as a new bus source, and out_en driven by a new controller signal.

Verification (bench parameters: DEBOUNCE=4, DEPTH=4)
REQ-029 Step pins 00 to 5A and hold -> avail rises 7 cycles later; out_en pulse -> out=16'h805A, then avail=0.
REQ-030 Pulse pins to FF for 3 cycles, then back to 00 -> no push; avail stays 0.
REQ-031 Make 5 distinct stable changes (11, 22, 33, 44, 55) with no reads -> four reads return 8011, 8022, 8033, 8044 with bit14=1 on the first; 55 is dropped; a fifth read returns 0000.
REQ-032 Hold the FIFO full (11..44) and pop on the exact cycle a push of 55 occurs -> no ovf; subsequent reads return 22, 33, 44, 55.
REQ-033 Assert rst low mid-debounce with 2 entries queued -> out=0000 and avail=0 immediately; pins held at 3C through release -> a single push of 3C.
REQ-034 Hold out_en continuously with the FIFO empty, then make 1 change to 7E -> exactly one 807E word appears, followed by 0000 words.
